mem_stage: RTL and testbench

//  MEM-stage data memory. Sits between the EX/MEM buffer and the MEM/WB buffer.
//  - Performs byte, half and word loads/stores with a fixed number of wait states.
//  - Stalls the pipeline while an access is in flight.
//  - ou_red feeds MEM/WB in_red directly; MEM/WB captures it on the edge where ou_stall=0.

---
 rtl/mem_stage_if.sv | 33 +++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Request/response bundle between the EX/MEM buffer and the MEM-stage data
//   memory.
//   master (pipeline side): drives in_*, observes ou_*
//   slave  (mem_stage)    : observes in_*, drives ou_*
//   in_MemRead, in_MemWrite : load / store request
//   in_size                 : 00 byte, 01 half, 10/11 word
//   in_unsigned             : 1 = zero-extend loads
//   in_addr, in_wdata       : byte address, right-justified store data
//   ou_red                  : load data, valid when ou_stall=0
//   ou_stall                : hold upstream stages, MEM/WB must not capture
//   ou_misaligned           : current request was misaligned and dropped
interface mem_stage_if;
    logic        in_MemRead;
    logic        in_MemWrite;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] ou_red;
    logic        ou_stall;
    logic        ou_misaligned;

    modport master (
        output in_MemRead, in_MemWrite, in_size, in_unsigned, in_addr, in_wdata,
        input  ou_red, ou_stall, ou_misaligned
    );

    modport slave (
        input  in_MemRead, in_MemWrite, in_size, in_unsigned, in_addr, in_wdata,
        output ou_red, ou_stall, ou_misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   MEM-stage data memory with a fixed number of wait states per access.
//   Byte/half/word loads and stores, little-endian, sign/zero-extended loads.
//   Ports:
//     clk          : clock, all state on posedge
//     rst          : synchronous active-high reset
//     bus          : mem_stage_if.slave request/response bundle
//     ou_stall_cnt : saturating count of stall cycles (only when
//                    MEM_STAGE_PERF_EN is defined)
//   Parameters:
//     DEPTH_WORDS  : memory size in 32-bit words (power of 2, >= 4)
//     WAIT_STATES  : extra cycles per access, 0..15
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no access in flight; an aligned request starts (or, with no
//         | wait states, completes) here
//   WAIT  | access in flight; counter runs down, completes at cnt==0
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_STAGE_PERF_EN
    output logic [31:0] ou_stall_cnt,
`endif
    mem_stage_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        stall;
    logic        complete;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic          req;
    logic          is_byte, is_half;
    logic          misaligned;
    logic          aligned_req;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic          write_en;
    logic          load_en;
    logic [31:0]   rword;
    logic [31:0]   load_val;

    // Address bits above the word index are deliberately ignored (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.in_addr[31:AW+2];

    assign widx        = bus.in_addr[AW+1:2];
    assign req         = bus.in_MemRead | bus.in_MemWrite;
    assign is_byte     = (bus.in_size == 2'b00);
    assign is_half     = (bus.in_size == 2'b01);
    assign misaligned  = req & ((is_half & bus.in_addr[0]) |
                                (!is_byte && !is_half && (bus.in_addr[1:0] != 2'b00)));
    assign aligned_req = req & ~misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (aligned_req) begin
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    complete  = aligned_req;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte enables and lane-replicated write data.
    always_comb begin
        be     = 4'b1111;
        wlanes = bus.in_wdata;
        if (is_byte) begin
            be     = 4'b0001 << bus.in_addr[1:0];
            wlanes = {4{bus.in_wdata[7:0]}};
        end else if (is_half) begin
            be     = bus.in_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{bus.in_wdata[15:0]}};
        end
    end

    // A reset on the completion edge abandons the store.
    assign write_en = complete & bus.in_MemWrite & ~rst;
    assign load_en  = complete & bus.in_MemRead & ~bus.in_MemWrite & ~rst;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (write_en && be[i]) begin
                mem[widx][i*8 +: 8] <= wlanes[i*8 +: 8];
            end
        end
    end

    assign rword = mem[widx];

    always_comb begin
        load_val = rword;
        if (is_byte) begin
            load_val[7:0]  = rword[bus.in_addr[1:0]*8 +: 8];
            load_val[31:8] = bus.in_unsigned ? 24'd0 : {24{load_val[7]}};
        end else if (is_half) begin
            load_val[15:0]  = bus.in_addr[1] ? rword[31:16] : rword[15:0];
            load_val[31:16] = bus.in_unsigned ? 16'd0 : {16{load_val[15]}};
        end
    end

    assign bus.ou_red        = load_en ? load_val : 32'd0;
    assign bus.ou_stall      = stall;
    assign bus.ou_misaligned = misaligned;

`ifdef MEM_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ou_stall_cnt <= 32'd0;
        end else if (stall && (ou_stall_cnt != 32'hFFFF_FFFF)) begin
            ou_stall_cnt <= ou_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed bench for mem_stage. Two instances share the request inputs:
//   dut_ws1 (WAIT_STATES=1) and dut_ws3 (WAIT_STATES=3); whichever is not
//   under test is held in reset so it neither stalls nor writes.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst1, rst3;
    logic sel3;            // 0: observe dut_ws1, 1: observe dut_ws3

    logic        rd, wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    mem_stage_if bus1 ();
    mem_stage_if bus3 ();

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] scnt1, scnt3;
`endif

    mem_stage #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .rst(rst1),
`ifdef MEM_STAGE_PERF_EN
        .ou_stall_cnt(scnt1),
`endif
        .bus(bus1.slave)
    );

    mem_stage #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .rst(rst3),
`ifdef MEM_STAGE_PERF_EN
        .ou_stall_cnt(scnt3),
`endif
        .bus(bus3.slave)
    );

    assign bus1.in_MemRead  = rd;
    assign bus1.in_MemWrite = wr;
    assign bus1.in_size     = size;
    assign bus1.in_unsigned = uns;
    assign bus1.in_addr     = addr;
    assign bus1.in_wdata    = wdata;
    assign bus3.in_MemRead  = rd;
    assign bus3.in_MemWrite = wr;
    assign bus3.in_size     = size;
    assign bus3.in_unsigned = uns;
    assign bus3.in_addr     = addr;
    assign bus3.in_wdata    = wdata;

    logic [31:0] obs_red;
    logic        obs_stall, obs_mis;
    assign obs_red   = sel3 ? bus3.ou_red        : bus1.ou_red;
    assign obs_stall = sel3 ? bus3.ou_stall      : bus1.ou_stall;
    assign obs_mis   = sel3 ? bus3.ou_misaligned : bus1.ou_misaligned;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rd = 1'b0; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    endtask

    // One access: drive at negedge, count stall cycles, sample completion data.
    task automatic access(input logic r, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] red, output int stalls, output logic mis);
        int n;
        @(negedge clk);
        rd = r; wr = w; size = sz; uns = u; addr = a; wdata = d;
        #1;
        n = 0;
        while (obs_stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_bound", (n < 40) ? 32'd1 : 32'd0, 32'd1);
        red    = obs_red;
        mis    = obs_mis;
        stalls = n;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    logic [31:0] red;
    int          st;
    logic        mis;

    initial begin
        idle_inputs();
        sel3 = 1'b0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_stall", {31'd0, obs_stall}, 32'd0);
        chk("rst_mis",   {31'd0, obs_mis},   32'd0);
        chk("rst_red",   obs_red,            32'd0);
`ifdef MEM_STAGE_PERF_EN
        chk("rst_scnt",  scnt1,              32'd0);
`endif

        // SW / LW word
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, red, st, mis);
        chk("sw_stalls", st,  32'd1);
        chk("sw_red",    red, 32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, red, st, mis);
        chk("lw_stalls", st,  32'd1);
        chk("lw_red",    red, 32'hDEADBEEF);

        // Byte store, signed / unsigned loads
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h80, red, st, mis);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, red, st, mis);
        chk("lb_signed",   red, 32'hFFFFFF80);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, red, st, mis);
        chk("lb_unsigned", red, 32'h00000080);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, red, st, mis);
        chk("lw_after_sb", red, 32'h80ADBEEF);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, red, st, mis);
        chk("lh_signed",   red, 32'hFFFF80AD);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, red, st, mis);
        chk("lhu",         red, 32'h000080AD);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'd0, red, st, mis);
        chk("lbu_lane0",   red, 32'h000000EF);

        // Idle: no load completing
        @(negedge clk);
        chk("idle_red", obs_red, 32'd0);

        // Misaligned requests
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, red, st, mis);
        chk("lh_mis_flag",   {31'd0, mis}, 32'd1);
        chk("lh_mis_stalls", st,           32'd0);
        chk("lh_mis_red",    red,          32'd0);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, red, st, mis);
        chk("sw_mis_flag",   {31'd0, mis}, 32'd1);
        chk("sw_mis_stalls", st,           32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, red, st, mis);
        chk("lw_after_mis",  red,          32'h80ADBEEF);
        chk("lw_aligned_mis",{31'd0, mis}, 32'd0);

        // Half store upper lane, then read+write together treated as store
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, red, st, mis);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, red, st, mis);
        chk("lw_after_sh", red, 32'h1234BEEF);
        access(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h11, red, st, mis);
        chk("rw_red",    red, 32'd0);
        chk("rw_stalls", st,  32'd1);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, red, st, mis);
        chk("lw_after_rw", red, 32'h1234BE11);

        // Wrap-around: word 257 aliases word 1
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd1028, 32'hA5A55A5A, red, st, mis);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, red, st, mis);
        chk("wrap_lw", red, 32'hA5A55A5A);

        // Switch to the 3-wait-state instance
        @(negedge clk);
        rst1 = 1'b1;
        sel3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst3 = 1'b0;
`ifdef MEM_STAGE_PERF_EN
        @(negedge clk);
        chk("ws3_rst_scnt", scnt3, 32'd0);
`endif
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, red, st, mis);
        chk("ws3_sw_stalls", st, 32'd3);
`ifdef MEM_STAGE_PERF_EN
        chk("ws3_scnt", scnt3, 32'd3);
`endif

        // Store abandoned by reset after one stall cycle
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
        #1;
        chk("ws3_abort_stall", {31'd0, obs_stall}, 32'd1);
        @(posedge clk);
        #1 rst3 = 1'b1;
        @(posedge clk);
        #1 rst3 = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("ws3_after_rst_stall", {31'd0, obs_stall}, 32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, red, st, mis);
        chk("ws3_lw_stalls", st,  32'd3);
        chk("ws3_lw_prior",  red, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
